alu_rr_issue_arbiter: RTL and testbench

//  Shares one pipelined 64-bit ALU (ops ADD=0 SUB=1 MUL=2 NAND=3 ROR=4 SGT=5 AND=6) among NUM_REQ requesters.

---
 rtl/alu_rr_issue_arbiter_pkg.sv | 29 ++
 rtl/alu_rr_issue_arbiter_rr_pick.sv | 32 +++
 rtl/alu_rr_issue_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_alu_rr_issue_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rr_issue_arbiter_pkg.sv
// Shared definitions for the ALU issue arbiter: opcode values, flush FSM
// state encoding and small opcode classification helpers.
package alu_pkg;

   localparam logic [31:0] OP_ADD  = 32'd0;
   localparam logic [31:0] OP_SUB  = 32'd1;
   localparam logic [31:0] OP_MUL  = 32'd2;
   localparam logic [31:0] OP_NAND = 32'd3;
   localparam logic [31:0] OP_ROR  = 32'd4;
   localparam logic [31:0] OP_SGT  = 32'd5;
   localparam logic [31:0] OP_AND  = 32'd6;
   localparam logic [31:0] OP_MAX  = 32'd6;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } fsm_state_t;

   // Only ADD and SUB refresh the ALU flags; every other op leaves them stale.
   function automatic logic is_addsub(input logic [31:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic is_illegal(input logic [31:0] op);
      return op > OP_MAX;
   endfunction

endpackage

// File: rtl/alu_rr_issue_arbiter_rr_pick.sv
// Combinational round-robin pick: the first asserted request at or after
// ptr, searching circularly. Returns a one-hot grant and its index.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     gnt_idx,
   output logic               gnt_any
);

   int cand;

   // Circular scan starting at ptr; the first hit wins
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (!gnt_any && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = IDW'(cand);
            gnt_any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rr_issue_arbiter.sv
// Shares one pipelined ALU among NUM_REQ requesters. Round-robin grant,
// one registered issue per cycle, a tag pipe that follows each op through
// the ALU so its result returns to the issuer, and a flush handshake that
// drains the pipe before reconfiguration.
module alu_rr_issue_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 64,
   parameter int OPW     = 4,
   parameter int SHW     = 5,
   parameter int ALU_LAT = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*OPW-1:0] req_opcode,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ*SHW-1:0] req_shift,
   input  logic [NUM_REQ-1:0]     cfg_enable,
   input  logic                   flush_req,
   output logic                   flush_done,
   output logic [OPW-1:0]         alu_opcode,
   output logic [WIDTH-1:0]       alu_input1,
   output logic [WIDTH-1:0]       alu_input2,
   output logic [SHW-1:0]         alu_shift,
   input  logic [WIDTH-1:0]       alu_result,
   input  logic                   alu_carry,
   input  logic                   alu_ovf,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [WIDTH-1:0]       rsp_result,
   output logic                   rsp_carry,
   output logic                   rsp_zero,
   output logic                   rsp_ovf,
   output logic                   rsp_err
);

   localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int DEPTH = ALU_LAT + 1;
   localparam int LAST  = DEPTH - 1;

   fsm_state_t           state;
   logic [IDW-1:0]       ptr;
   logic [NUM_REQ-1:0]   pick_gnt;
   logic [IDW-1:0]       pick_idx;
   logic                 pick_any;
   logic                 issue_ok;
   logic                 accept;
   logic [OPW-1:0]       sel_op;
   logic [WIDTH-1:0]     sel_a;
   logic [WIDTH-1:0]     sel_b;
   logic [SHW-1:0]       sel_sh;
   logic                 vld_p [DEPTH];
   logic [IDW-1:0]       id_p  [DEPTH];
   logic [OPW-1:0]       op_p  [DEPTH];
   logic                 pipe_busy;
   logic [NUM_REQ-1:0]   rsp_hit;
   logic [WIDTH-1:0]     rsp_res_c;
   logic                 rsp_err_c;
   logic                 rsp_flags_c;

   // Grants are offered only while running with no flush pending; reset
   // forces the (combinational) ready vector to zero as well.
   assign issue_ok  = rst_n && (state == ST_RUN) && !flush_req;
   assign req_ready = issue_ok ? pick_gnt : '0;
   assign accept    = issue_ok && pick_any;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .req     (req_valid & cfg_enable),
      .ptr     (ptr),
      .gnt     (pick_gnt),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   // Route the granted requester's fields toward the issue registers
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      sel_sh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) begin
            sel_op = req_opcode[i*OPW +: OPW];
            sel_a  = req_a[i*WIDTH +: WIDTH];
            sel_b  = req_b[i*WIDTH +: WIDTH];
            sel_sh = req_shift[i*SHW +: SHW];
         end
      end
   end

   // Issue stage (p0): load ALU operands and advance the RR pointer on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode <= '0;
         alu_input1 <= '0;
         alu_input2 <= '0;
         alu_shift  <= '0;
         ptr        <= '0;
      end else if (accept) begin
         alu_opcode <= sel_op;
         alu_input1 <= sel_a;
         alu_input2 <= sel_b;
         alu_shift  <= sel_sh;
         ptr        <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
      end
   end

   // Tag valid pipe: reset discards every in-flight op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < DEPTH; s++) vld_p[s] <= 1'b0;
      end else begin
         vld_p[0] <= accept;
         for (int s = 1; s < DEPTH; s++) vld_p[s] <= vld_p[s-1];
      end
   end

   // Tag payload pipe: qualified by vld_p, so it needs no reset
   always_ff @(posedge clk) begin
      id_p[0] <= pick_idx;
      op_p[0] <= sel_op;
      for (int s = 1; s < DEPTH; s++) begin
         id_p[s] <= id_p[s-1];
         op_p[s] <= op_p[s-1];
      end
   end

   // Any op still travelling through the ALU
   always_comb begin
      pipe_busy = 1'b0;
      for (int s = 0; s < DEPTH; s++) pipe_busy = pipe_busy | vld_p[s];
   end

   // Flush FSM: stop issuing, wait for the pipe to empty, hold DONE until released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         flush_done <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               flush_done <= 1'b0;
               if (flush_req) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!pipe_busy) begin
                  state      <= ST_DONE;
                  flush_done <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!flush_req) begin
                  state      <= ST_RUN;
                  flush_done <= 1'b0;
               end
            end
            default: begin
               state      <= ST_RUN;
               flush_done <= 1'b0;
            end
         endcase
      end
   end

   // Qualify the ALU outputs against the tag leaving the pipe
   always_comb begin
      rsp_err_c   = is_illegal(32'(op_p[LAST]));
      rsp_flags_c = is_addsub(32'(op_p[LAST]));
      rsp_res_c   = rsp_err_c ? '0 : alu_result;
      rsp_hit     = '0;
      for (int i = 0; i < NUM_REQ; i++) rsp_hit[i] = (id_p[LAST] == IDW'(i));
   end

   // Response stage: one-cycle strobe, data held between responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_ovf    <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         rsp_valid <= vld_p[LAST] ? rsp_hit : '0;
         if (vld_p[LAST]) begin
            rsp_result <= rsp_res_c;
            rsp_zero   <= (rsp_res_c == '0);
            rsp_carry  <= rsp_flags_c & alu_carry;
            rsp_ovf    <= rsp_flags_c & alu_ovf;
            rsp_err    <= rsp_err_c;
         end
      end
   end

endmodule

// File: tb/tb_alu_rr_issue_arbiter.sv
// Bench for alu_rr_issue_arbiter: drives an ALU model with two-edge
// latency, keeps a queue-based reference of issued ops and the flush mode,
// and compares every output each cycle plus literal expectations.
module tb_alu_rr_issue_arbiter;
   import alu_pkg::*;

   localparam int N = 4, W = 64, OPW = 4, SHW = 5;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0, cfg_enable = '0;
   logic [N-1:0]     req_ready, rsp_valid;
   logic [N*OPW-1:0] req_opcode = '0;
   logic [N*W-1:0]   req_a = '0, req_b = '0;
   logic [N*SHW-1:0] req_shift = '0;
   logic             flush_req = 1'b0, flush_done;
   logic [OPW-1:0]   alu_opcode;
   logic [W-1:0]     alu_input1, alu_input2;
   logic [SHW-1:0]   alu_shift;
   logic [W-1:0]     alu_result = '0;
   logic             alu_carry = 1'b0, alu_ovf = 1'b0;
   logic [W-1:0]     rsp_result;
   logic             rsp_carry, rsp_zero, rsp_ovf, rsp_err;

   always #5 clk = ~clk;

   alu_rr_issue_arbiter #(.NUM_REQ(N), .WIDTH(W), .OPW(OPW), .SHW(SHW), .ALU_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
      .cfg_enable(cfg_enable), .flush_req(flush_req), .flush_done(flush_done),
      .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
      .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
      .alu_ovf(alu_ovf), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
   );

   // Arithmetic behaviour of the shared ALU
   function automatic void ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [4:0] sh, output logic [63:0] r, output logic c,
                                   output logic o);
      logic [64:0] s;
      r = '0; c = 1'b0; o = 1'b0;
      case (32'(op))
         OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; r = s[63:0]; c = s[64];
                        o = (a[63] == b[63]) && (r[63] != a[63]); end
         OP_SUB:  begin r = a - b; c = (a < b); o = (a[63] != b[63]) && (r[63] != a[63]); end
         OP_MUL:  r = a * b;
         OP_NAND: r = ~(a & b);
         OP_ROR:  r = (a >> sh) | (a << (64 - int'(sh)));
         OP_SGT:  r = ($signed(a) > $signed(b)) ? 64'd1 : 64'd0;
         OP_AND:  r = a & b;
         default: r = 64'hBAD0_BAD0_BAD0_BAD0;
      endcase
   endfunction

   // ALU model: two clock edges from inputs to outputs, flags only refreshed by ADD/SUB
   logic [63:0] c_r, s1_r = '0;
   logic        c_c, c_o, s1_c = 1'b0, s1_o = 1'b0, s1_f = 1'b0;
   always_comb begin
      c_r = '0; c_c = 1'b0; c_o = 1'b0;
      ref_alu(alu_opcode, alu_input1, alu_input2, alu_shift, c_r, c_c, c_o);
   end
   always @(posedge clk) begin
      s1_r <= c_r; s1_c <= c_c; s1_o <= c_o; s1_f <= is_addsub(32'(alu_opcode));
      alu_result <= s1_r;
      if (s1_f) begin alu_carry <= s1_c; alu_ovf <= s1_o; end
   end

   // Reference model state
   typedef struct { int id; logic [63:0] res; logic c, z, o, e; int due; } exp_t;
   exp_t        q[$];
   int          m_ptr, m_mode, E, n_chk, n_pass;
   logic [N-1:0] e_rdy;
   int          e_idx;
   bit          e_any;
   logic [63:0] h_res, h_a;
   logic        h_c, h_z, h_o, h_e;
   logic [3:0]  h_op;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      q.delete(); m_ptr = 0; m_mode = 0;
      h_res = '0; h_a = '0; h_op = '0; h_c = 0; h_z = 0; h_o = 0; h_e = 0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", req_ready, 0);   chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_result", rsp_result, 0); chk("rst_carry", rsp_carry, 0);
      chk("rst_zero", rsp_zero, 0);     chk("rst_ovf", rsp_ovf, 0);
      chk("rst_err", rsp_err, 0);       chk("rst_flush_done", flush_done, 0);
      chk("rst_alu_op", alu_opcode, 0); chk("rst_alu_in1", alu_input1, 0);
      chk("rst_alu_in2", alu_input2, 0); chk("rst_alu_sh", alu_shift, 0);
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] sh);
      req_opcode[i*OPW +: OPW] = op; req_a[i*W +: W] = a;
      req_b[i*W +: W] = b; req_shift[i*SHW +: SHW] = sh;
   endtask

   // Round-robin rule: first enabled, valid requester at or after ptr (circular)
   task automatic model_grant();
      e_rdy = '0; e_any = 0; e_idx = 0;
      if (rst_n && m_mode == 0 && !flush_req)
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!e_any && req_valid[j] && cfg_enable[j]) begin e_any = 1; e_idx = j; e_rdy[j] = 1'b1; end
         end
   endtask

   // One clock: called at a negedge after inputs are driven
   task automatic step();
      logic [N-1:0] ev;
      model_grant();
      #1 chk("req_ready", req_ready, e_rdy);
      @(posedge clk);
      E++;
      case (m_mode)
         0: if (flush_req) m_mode = 1;
            else if (e_any) begin
               exp_t x; logic [3:0] op; logic [63:0] a, b, r; logic [4:0] sh; logic c, o;
               op = req_opcode[e_idx*OPW +: OPW]; a = req_a[e_idx*W +: W];
               b = req_b[e_idx*W +: W]; sh = req_shift[e_idx*SHW +: SHW];
               ref_alu(op, a, b, sh, r, c, o);
               x.id = e_idx; x.e = (32'(op) > OP_MAX); x.res = x.e ? 64'd0 : r;
               x.c = is_addsub(32'(op)) ? c : 1'b0; x.o = is_addsub(32'(op)) ? o : 1'b0;
               x.z = (x.res == 64'd0); x.due = E + 3;
               q.push_back(x);
               m_ptr = (e_idx + 1) % N; h_op = op; h_a = a;
            end
         1: if (q.size() == 0) m_mode = 2;
         default: if (!flush_req) m_mode = 0;
      endcase
      @(negedge clk);
      ev = '0;
      if (q.size() > 0 && q[0].due == E) begin
         ev = 4'd1 << q[0].id;
         h_res = q[0].res; h_c = q[0].c; h_z = q[0].z; h_o = q[0].o; h_e = q[0].e;
         void'(q.pop_front());
      end
      chk("rsp_valid", rsp_valid, ev);  chk("rsp_result", rsp_result, h_res);
      chk("rsp_carry", rsp_carry, h_c); chk("rsp_zero", rsp_zero, h_z);
      chk("rsp_ovf", rsp_ovf, h_o);     chk("rsp_err", rsp_err, h_e);
      chk("flush_done", flush_done, (m_mode == 2));
      chk("alu_opcode", alu_opcode, h_op); chk("alu_input1", alu_input1, h_a);
   endtask

   task automatic rand_reqs();
      for (int i = 0; i < N; i++)
         set_req(i, 4'($urandom_range(0, 8)),
                 ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
                 ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
                 5'($urandom));
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      repeat (n) step();
   endtask

   initial begin
      int nresp;
      bit got;
      n_chk = 0; n_pass = 0; E = 0;
      model_reset();
      cfg_enable = '1; req_valid = '1;
      repeat (2) @(posedge clk);
      #1 chk_reset_outputs();
      @(negedge clk); rst_n = 1'b1; req_valid = '0;

      // Single ADD with carry out and zero result
      set_req(0, 4'(OP_ADD), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0);
      req_valid = 4'b0001; step(); idle(3);
      chk("t1_valid", rsp_valid, 4'b0001); chk("t1_result", rsp_result, 0);
      chk("t1_carry", rsp_carry, 1); chk("t1_zero", rsp_zero, 1); chk("t1_ovf", rsp_ovf, 0);

      // All requesters valid: grants rotate from ptr = 1
      for (int k = 0; k < 8; k++) begin
         rand_reqs(); req_valid = '1;
         #1 chk("t2_grant", req_ready, 4'b0001 << ((1 + k) % 4));
         step();
      end
      idle(4);

      // SUB on req0 followed by MUL on req1
      set_req(0, 4'(OP_SUB), 64'd5, 64'd3, 5'd0); req_valid = 4'b0001; step();
      set_req(1, 4'(OP_MUL), 64'd3, 64'd5, 5'd0); req_valid = 4'b0010; step();
      idle(2);
      chk("t3_sub_valid", rsp_valid, 4'b0001); chk("t3_sub_result", rsp_result, 2);
      chk("t3_sub_carry", rsp_carry, 0);
      step();
      chk("t3_mul_valid", rsp_valid, 4'b0010); chk("t3_mul_result", rsp_result, 15);
      chk("t3_mul_carry", rsp_carry, 0); chk("t3_mul_ovf", rsp_ovf, 0);
      idle(4);

      // Only requesters 1 and 3 enabled (ptr = 2)
      cfg_enable = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         rand_reqs(); req_valid = '1;
         #1 chk("t4_grant", req_ready, (k % 2 == 0) ? 4'b1000 : 4'b0010);
         step();
      end
      cfg_enable = '1; idle(4);

      // Flush with three ops in flight (grants 2,3,0 -> ptr = 1)
      req_valid = '1;
      repeat (3) begin rand_reqs(); step(); end
      flush_req = 1'b1;
      #1 chk("t5_blocked", req_ready, 0);
      nresp = 0; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (rsp_valid != '0) nresp++;
         if (flush_done) got = 1;
      end
      chk("t5_done_seen", got, 1); chk("t5_responses", nresp, 3);
      flush_req = 1'b0; idle(1);
      req_valid = '1;
      #1 chk("t5_resume", req_ready, 4'b0010);
      step(); idle(4);

      // Reset with two ops in flight, then an illegal opcode
      req_valid = '1; rand_reqs(); step(); step(); req_valid = '0;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs();
      model_reset();
      @(posedge clk); @(negedge clk); rst_n = 1'b1;
      idle(5);
      set_req(2, 4'd9, 64'd123, 64'd456, 5'd0); req_valid = 4'b0100; step(); idle(3);
      chk("t6_valid", rsp_valid, 4'b0100); chk("t6_err", rsp_err, 1);
      chk("t6_result", rsp_result, 0);

      // Randomized traffic with occasional masks and flush toggles
      for (int c = 0; c < 600; c++) begin
         rand_reqs();
         req_valid  = 4'($urandom);
         cfg_enable = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
         if ($urandom_range(0, 39) == 0) flush_req = ~flush_req;
         step();
      end
      flush_req = 1'b0; idle(8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
